curl_pow_sequencer: RTL

Job-level controller in front of one curl_pow core. It accepts a PoW job: chunk count, MWM mask and iteration limit, plus a stream of 54-bit state words (27 trits, 2 bits per trit). It absorbs all but the last chunk via transform, loads the last chunk and launches PoW. It returns the nonce with a status, and enforces timeout and abort by resetting the core.

---
 rtl/curl_pkg.sv | 31 +++
 rtl/curl_rst_gen.sv | 43 ++++
 rtl/curl_pow_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/curl_pkg.sv
// Shared widths and enums for the curl PoW job sequencer and its helpers.
package curl_pkg;

   localparam int unsigned DATA_WIDTH     = 54;
   localparam int unsigned STATE_WORDS_IO = 9;
   localparam int unsigned NONCE_BITS     = 162;
   localparam int unsigned MWM_MASK_WIDTH = 32;
   localparam int unsigned WORD_IDX_W     = 4;

   typedef enum logic [1:0] {
      RES_FOUND   = 2'b00,
      RES_TIMEOUT = 2'b01,
      RES_ABORTED = 2'b10
   } res_status_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLR,
      S_LOAD,
      S_TF_PULSE,
      S_TF_SETTLE,
      S_TF_WAIT,
      S_POW_PULSE,
      S_POW_WAIT,
      S_POW_LAST,
      S_TMO_CLR,
      S_ABT_CLR,
      S_RESULT
   } seq_state_e;

endpackage

// File: rtl/curl_rst_gen.sv
// Core reset pulse generator: holds o_curl_arst_n low for CURL_RST_CYCLES cycles per start.
module curl_rst_gen #(
   parameter int unsigned CURL_RST_CYCLES = 2
) (
   input  logic i_clk,
   input  logic i_arst,
   input  logic i_start,
   output logic o_curl_arst_n,
   output logic o_done_c
);

   localparam int unsigned CNT_W = $clog2(CURL_RST_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             arst_n_q, arst_n_d;

   // Release on the cycle the counter steps from 1 to 0; a restart reloads.
   always_comb begin
      cnt_d    = cnt_q;
      arst_n_d = arst_n_q;
      if (i_start) begin
         cnt_d    = CNT_W'(CURL_RST_CYCLES);
         arst_n_d = 1'b0;
      end else if (cnt_q != '0) begin
         cnt_d    = cnt_q - CNT_W'(1);
         arst_n_d = (cnt_q == CNT_W'(1));
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         cnt_q    <= '0;
         arst_n_q <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         arst_n_q <= arst_n_d;
      end
   end

   assign o_curl_arst_n = arst_n_q;
   assign o_done_c      = (cnt_q == '0);

endmodule

// File: rtl/curl_pow_sequencer.sv
// Job-level controller for one curl_pow core: clear, absorb chunks, launch PoW,
// report nonce/status, and enforce iteration timeout and abort.
module curl_pow_sequencer
   import curl_pkg::*;
#(
   parameter int unsigned CHUNK_CNT_W     = 8,
   parameter int unsigned ITER_W          = 32,
   parameter int unsigned CURL_RST_CYCLES = 2
) (
   input  logic                      i_clk,
   input  logic                      i_arst,
   input  logic                      i_job_valid,
   output logic                      o_job_ready,
   input  logic [CHUNK_CNT_W-1:0]    i_job_chunks,
   input  logic [MWM_MASK_WIDTH-1:0] i_mwm_mask,
   input  logic [ITER_W-1:0]         i_max_iter,
   input  logic                      i_word_valid,
   output logic                      o_word_ready,
   input  logic [DATA_WIDTH-1:0]     i_word_data,
   input  logic                      i_abort,
   output logic                      o_curl_arst_n,
   output logic                      o_curl_we,
   output logic [WORD_IDX_W-1:0]     o_curl_addr,
   output logic [DATA_WIDTH-1:0]     o_curl_data,
   output logic                      o_curl_transform,
   output logic                      o_curl_pow,
   output logic [MWM_MASK_WIDTH-1:0] o_curl_mwm_mask,
   input  logic                      i_curl_transforming,
   input  logic                      i_curl_pow_finish,
   input  logic                      i_curl_pow_hash_finish,
   input  logic [NONCE_BITS-1:0]     i_curl_nonce,
   output logic                      o_res_valid,
   input  logic                      i_res_ready,
   output logic [NONCE_BITS-1:0]     o_res_nonce,
   output logic [1:0]                o_res_status,
   output logic [ITER_W-1:0]         o_iter_cnt,
   output logic                      o_busy
);

   seq_state_e                state_q, state_d;
   logic [CHUNK_CNT_W-1:0]    chunks_q, chunks_d;
   logic [CHUNK_CNT_W-1:0]    chunk_idx_q, chunk_idx_d;
   logic [WORD_IDX_W-1:0]     word_idx_q, word_idx_d;
   logic [ITER_W-1:0]         max_iter_q, max_iter_d;
   logic [ITER_W-1:0]         iter_q, iter_d;
   logic [MWM_MASK_WIDTH-1:0] mask_q, mask_d;
   logic [NONCE_BITS-1:0]     nonce_q, nonce_d;
   res_status_e               status_q, status_d;
   logic                      fin_q;

   logic              rst_start_c, rst_done_c;
   logic              abort_c, word_fire_c, last_word_c, last_chunk_c;
   logic              fin_rise_c, hit_limit_c;
   logic [ITER_W-1:0] iter_inc_c;

   curl_rst_gen #(
      .CURL_RST_CYCLES(CURL_RST_CYCLES)
   ) u_rst_gen (
      .i_clk        (i_clk),
      .i_arst       (i_arst),
      .i_start      (rst_start_c),
      .o_curl_arst_n(o_curl_arst_n),
      .o_done_c     (rst_done_c)
   );

   assign abort_c      = i_abort && (state_q != S_IDLE) && (state_q != S_RESULT);
   assign word_fire_c  = (state_q == S_LOAD) && !i_abort && i_word_valid;
   assign last_word_c  = (word_idx_q == WORD_IDX_W'(STATE_WORDS_IO - 1));
   assign last_chunk_c = (chunk_idx_q == chunks_q - CHUNK_CNT_W'(1));
   assign fin_rise_c   = i_curl_pow_finish && !fin_q;
   assign iter_inc_c   = (&iter_q) ? iter_q : iter_q + ITER_W'(1);
   assign hit_limit_c  = i_curl_pow_hash_finish && (max_iter_q != '0) && (iter_inc_c == max_iter_q);

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state; abort preempts every busy state and restarts the core clear.
   always_comb begin
      state_d     = state_q;
      rst_start_c = 1'b0;
      if (abort_c) begin
         state_d     = S_ABT_CLR;
         rst_start_c = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: if (i_job_valid) begin
               state_d     = S_CLR;
               rst_start_c = 1'b1;
            end
            S_CLR:       if (rst_done_c) state_d = S_LOAD;
            S_LOAD:      if (word_fire_c && last_word_c)
                            state_d = last_chunk_c ? S_POW_PULSE : S_TF_PULSE;
            S_TF_PULSE:  state_d = S_TF_SETTLE;
            S_TF_SETTLE: state_d = S_TF_WAIT;
            S_TF_WAIT:   if (!i_curl_transforming) state_d = S_LOAD;
            S_POW_PULSE: state_d = S_POW_WAIT;
            S_POW_WAIT: begin
               if (fin_rise_c)       state_d = S_RESULT;
               else if (hit_limit_c) state_d = S_POW_LAST;
            end
            S_POW_LAST: begin
               if (i_curl_pow_finish) begin
                  state_d = S_RESULT;
               end else begin
                  state_d     = S_TMO_CLR;
                  rst_start_c = 1'b1;
               end
            end
            S_TMO_CLR, S_ABT_CLR: if (rst_done_c) state_d = S_RESULT;
            S_RESULT:    if (i_res_ready) state_d = S_IDLE;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   // Core-facing strobes are decoded live so an abort can squash them in the same cycle.
   always_comb begin
      o_job_ready      = (state_q == S_IDLE);
      o_busy           = (state_q != S_IDLE);
      o_res_valid      = (state_q == S_RESULT);
      o_word_ready     = (state_q == S_LOAD) && !i_abort;
      o_curl_we        = word_fire_c;
      o_curl_addr      = '0;
      o_curl_data      = '0;
      o_curl_transform = (state_q == S_TF_PULSE) && !i_abort;
      o_curl_pow       = (state_q == S_POW_PULSE) && !i_abort;
      if (word_fire_c) begin
         o_curl_addr = word_idx_q;
         o_curl_data = i_word_data;
      end
   end

   always_comb begin
      chunks_d    = chunks_q;
      chunk_idx_d = chunk_idx_q;
      word_idx_d  = word_idx_q;
      max_iter_d  = max_iter_q;
      iter_d      = iter_q;
      mask_d      = mask_q;
      nonce_d     = nonce_q;
      status_d    = status_q;
      if (state_q == S_IDLE && i_job_valid) begin
         chunks_d    = (i_job_chunks == '0) ? CHUNK_CNT_W'(1) : i_job_chunks;
         mask_d      = i_mwm_mask;
         max_iter_d  = i_max_iter;
         iter_d      = '0;
         chunk_idx_d = '0;
         word_idx_d  = '0;
         nonce_d     = '0;
         status_d    = RES_FOUND;
      end
      if (abort_c) begin
         nonce_d  = '0;
         status_d = RES_ABORTED;
      end else begin
         case (state_q)
            S_LOAD: if (word_fire_c)
               word_idx_d = last_word_c ? '0 : word_idx_q + WORD_IDX_W'(1);
            S_TF_WAIT: if (!i_curl_transforming)
               chunk_idx_d = chunk_idx_q + CHUNK_CNT_W'(1);
            S_POW_WAIT: begin
               if (i_curl_pow_hash_finish) iter_d = iter_inc_c;
               if (fin_rise_c) begin
                  nonce_d  = i_curl_nonce;
                  status_d = RES_FOUND;
               end
            end
            // Success lands one cycle after the final hash, so it still wins here.
            S_POW_LAST: begin
               if (i_curl_pow_finish) begin
                  nonce_d  = i_curl_nonce;
                  status_d = RES_FOUND;
               end else begin
                  nonce_d  = '0;
                  status_d = RES_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         chunks_q    <= '0;
         chunk_idx_q <= '0;
         word_idx_q  <= '0;
         max_iter_q  <= '0;
         iter_q      <= '0;
         mask_q      <= '0;
         nonce_q     <= '0;
         status_q    <= RES_FOUND;
         fin_q       <= 1'b0;
      end else begin
         chunks_q    <= chunks_d;
         chunk_idx_q <= chunk_idx_d;
         word_idx_q  <= word_idx_d;
         max_iter_q  <= max_iter_d;
         iter_q      <= iter_d;
         mask_q      <= mask_d;
         nonce_q     <= nonce_d;
         status_q    <= status_d;
         fin_q       <= i_curl_pow_finish;
      end
   end

   assign o_curl_mwm_mask = mask_q;
   assign o_res_nonce     = nonce_q;
   assign o_res_status    = status_q;
   assign o_iter_cnt      = iter_q;

endmodule
